regfile_multiport: RTL

Parametrised general-purpose register file for the datapath: one write port, NREAD registered read ports, optional hardwired-zero entry, write-to-read bypass, and a multi-cycle clear sweep with a busy flag. It sits between decode (read addresses) and writeback (write port) and replaces the fixed 32x32, two-read-port register bank.

---
 rtl/regfile_multiport_if.sv | 26 ++
 rtl/regfile_multiport.sv | 108 ++++++++++
 2 files changed

// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: read addresses/data, the write port,
// the clear request and the busy/wr_drop status flags.
interface regfile_multiport_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic [NREAD*AW-1:0]    raddr;
    logic [NREAD*WIDTH-1:0] rdata;
    logic                   wen;
    logic [AW-1:0]          waddr;
    logic [WIDTH-1:0]       wdata;
    logic                   clear;
    logic                   busy;
    logic                   wr_drop;

    modport master (
        output raddr, wen, waddr, wdata, clear,
        input  rdata, busy, wr_drop
    );

    modport slave (
        input  raddr, wen, waddr, wdata, clear,
        output rdata, busy, wr_drop
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-port register file: one write port, NREAD registered read ports with
// write bypass, optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_multiport #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic clock,
    input  logic reset,
    regfile_multiport_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                 state, state_next;
    logic [AW-1:0]          idx, idx_next;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic                   wr_acc;
    logic                   sweep_we;
    logic [NREAD*WIDTH-1:0] rdata_next;
    logic [NREAD*WIDTH-1:0] rdata_p1;
    logic                   wr_drop_p1;

    // Writes are only taken while idle; entry 0 is read-only when hardwired to zero.
    assign wr_acc   = bus.wen && (state == IDLE) &&
                      !((ZERO_REG != 0) && (bus.waddr == '0));
    assign sweep_we = (state == CLEAR);

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (bus.clear) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + AW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        rdata_next = '0;
        ra         = '0;
        rd         = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = bus.raddr[k*AW +: AW];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if (wr_acc && (bus.waddr == ra)) begin
                rd = bus.wdata;
            end else if (sweep_we && (idx == ra)) begin
                rd = '0;
            end else begin
                rd = mem[ra];
            end
            rdata_next[k*WIDTH +: WIDTH] = rd;
        end
    end

    // Stage p1: storage update, registered read data and drop flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            rdata_p1   <= '0;
            wr_drop_p1 <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            rdata_p1   <= rdata_next;
            wr_drop_p1 <= bus.wen && (state == CLEAR);
            if (wr_acc) begin
                mem[bus.waddr] <= bus.wdata;
            end
            if (sweep_we) begin
                mem[idx] <= '0;
            end
        end
    end

    assign bus.rdata   = rdata_p1;
    assign bus.busy    = (state == CLEAR);
    assign bus.wr_drop = wr_drop_p1;
endmodule
